// File: rtl/if_fetch_unit.sv
// Instruction-fetch bus master for the IF stage.
// Issues one outstanding read at a time on the instruction memory port.
// Returned {pc, instruction} pairs are queued toward ID in a small FIFO.
// A branch redirect flushes the queue and drops any response still in flight.
module if_fetch_unit #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_address,
  input  logic        branch_taken,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  output logic        inst_exc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_t;

  state_t            state;
  state_t            state_next;
  logic              discard;
  logic              discard_next;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [31:0]       req_pc;

  logic [31:0]       fifo_pc   [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic              fifo_exc  [FIFO_DEPTH];

  logic              aligned;
  logic              has_room;
  logic              push;
  logic              pop;
  logic              latch_req;
  logic [31:0]       push_pc;
  logic [31:0]       push_data;
  logic              push_exc;

  // Room is judged on the pre-pop count, so a pop never lets a request through early.
  assign aligned  = (pc_address[1:0] == 2'b00);
  assign has_room = (count < DEPTH_C);

  // Queue head is registered; payload is forced to zero whenever the head is empty.
  assign inst_valid = ~rst & (count != '0);
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;
  assign inst_data  = inst_valid ? fifo_data[rd_ptr] : 32'h0;
  assign inst_exc   = inst_valid & fifo_exc[rd_ptr];
  assign pop        = inst_valid & inst_ready & ~branch_taken;
  assign imem_addr  = imem_req ? pc_address : 32'h0;

  // Next-state, bus request, PC enable and queue-push selection.
  always_comb begin
    state_next   = state;
    discard_next = discard;
    imem_req     = 1'b0;
    latch_req    = 1'b0;
    push         = 1'b0;
    push_pc      = pc_address;
    push_data    = NOP_WORD;
    push_exc     = 1'b0;
    case (state)
      S_REQ: begin
        if (!branch_taken && has_room) begin
          if (!aligned) begin
            push       = 1'b1;
            push_exc   = 1'b1;
            state_next = S_HALT;
          end else begin
            imem_req = 1'b1;
            if (imem_gnt) begin
              latch_req  = 1'b1;
              state_next = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_next = S_REQ;
          if (discard || branch_taken) begin
            discard_next = 1'b0;
          end else begin
            push      = 1'b1;
            push_pc   = req_pc;
            push_data = imem_rdata;
          end
        end else if (branch_taken) begin
          discard_next = 1'b1;
        end
      end
      S_HALT: begin
        if (branch_taken) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
    pc_en = latch_req | branch_taken;
    if (rst) begin
      imem_req  = 1'b0;
      latch_req = 1'b0;
      push      = 1'b0;
      pc_en     = 1'b0;
    end
  end

  // Control state: FSM, discard flag and queue pointers; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      discard <= 1'b0;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state   <= state_next;
      discard <= discard_next;
      if (branch_taken) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Data storage: queue entries and the address of the outstanding request.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= push_pc;
      fifo_data[wr_ptr] <= push_data;
      fifo_exc[wr_ptr]  <= push_exc;
    end
    if (latch_req) req_pc <= pc_address;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: PC register and memory responder around the DUT,
// a queue-based reference model compared every cycle, plus directed literal checks.
module tb_if_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_address = BOOT;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = 32'h0;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_exc;

  logic        gnt_en = 1'b1;
  int          rsp_delay = 2;
  int          n_checks = 0;
  int          n_err = 0;

  if_fetch_unit #(.FIFO_DEPTH(DEPTH), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc_address(pc_address), .branch_taken(branch_taken),
    .pc_en(pc_en), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_data(inst_data), .inst_exc(inst_exc)
  );

  always #5 clk = ~clk;

  assign imem_gnt = imem_req & gnt_en;

  // PC register fed by pc_en: loads the branch target on redirect, else steps by 4.
  always @(posedge clk) begin
    if (rst) pc_address <= BOOT;
    else if (pc_en) pc_address <= branch_taken ? branch_address : pc_address + 32'd4;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == BOOT) return 32'h3c08_0001;
    return {a[15:0] ^ 16'ha5a5, a[31:16]};
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: one read data beat rsp_delay cycles after each grant.
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = 32'h0;
  initial begin
    logic        g;
    logic        r;
    logic [31:0] a;
    forever begin
      @(posedge clk);
      g = imem_req & imem_gnt;
      r = rst;
      a = imem_addr;
      #1;
      if (r) rsp_cnt = 0;
      else if (g) begin
        rsp_cnt  = rsp_delay;
        rsp_addr = a;
      end else if (rsp_cnt > 0) rsp_cnt--;
      imem_rvalid = (rsp_cnt == 1);
      imem_rdata  = imem_rvalid ? mem_word(rsp_addr) : 32'h0;
    end
  end

  // Reference model: queue of expected entries plus fetch bookkeeping.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        exc;
  } ent_t;

  ent_t        mq[$];
  bit          m_busy = 0;
  bit          m_halt = 0;
  bit          m_drop = 0;
  logic [31:0] m_req_pc = 32'h0;

  initial begin
    ent_t e_head;
    bit   e_valid;
    bit   e_req;
    bit   e_room;
    bit   e_pc_en;
    bit   do_pop;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk1("rst inst_valid", inst_valid, 1'b0);
        chk32("rst inst_pc", inst_pc, 32'h0);
        chk32("rst inst_data", inst_data, 32'h0);
        chk1("rst inst_exc", inst_exc, 1'b0);
        chk1("rst imem_req", imem_req, 1'b0);
        chk32("rst imem_addr", imem_addr, 32'h0);
        chk1("rst pc_en", pc_en, 1'b0);
        mq.delete();
        m_busy = 0;
        m_halt = 0;
        m_drop = 0;
      end else begin
        e_valid = (mq.size() > 0);
        e_head  = e_valid ? mq[0] : '0;
        e_room  = (mq.size() < DEPTH);
        e_req   = !m_busy && !m_halt && (pc_address[1:0] == 2'b00) && e_room && !branch_taken;
        e_pc_en = (e_req && imem_gnt) || branch_taken;
        chk1("model inst_valid", inst_valid, e_valid);
        chk32("model inst_pc", inst_pc, e_head.pc);
        chk32("model inst_data", inst_data, e_head.data);
        chk1("model inst_exc", inst_exc, e_head.exc);
        chk1("model imem_req", imem_req, e_req);
        chk32("model imem_addr", imem_addr, e_req ? pc_address : 32'h0);
        chk1("model pc_en", pc_en, e_pc_en);
        do_pop = e_valid && inst_ready && !branch_taken;
        if (branch_taken) begin
          mq.delete();
          m_halt = 0;
          if (m_busy) begin
            if (imem_rvalid) begin
              m_busy = 0;
              m_drop = 0;
            end else m_drop = 1;
          end
        end else begin
          if (do_pop) void'(mq.pop_front());
          if (m_busy) begin
            if (imem_rvalid) begin
              if (m_drop) m_drop = 0;
              else mq.push_back('{pc: m_req_pc, data: imem_rdata, exc: 1'b0});
              m_busy = 0;
            end
          end else if (!m_halt) begin
            if (pc_address[1:0] != 2'b00) begin
              if (e_room) begin
                mq.push_back('{pc: pc_address, data: 32'h0, exc: 1'b1});
                m_halt = 1;
              end
            end else if (e_req && imem_gnt) begin
              m_busy   = 1;
              m_req_pc = pc_address;
            end
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) found = 1;
      else next_cycle();
    end
    n_checks++;
    if (!found) begin
      n_err++;
      $display("FAIL wait_grant: got no grant expected grant within 40 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Directed sequence with hand-computed literal expectations.
  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("t1 rst imem_req", imem_req, 1'b0);
    chk1("t1 rst inst_valid", inst_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    // t1/t2: first fetch from the boot vector, granted at once
    @(negedge clk);
    chk1("t1 imem_req", imem_req, 1'b1);
    chk32("t1 imem_addr", imem_addr, 32'hbfc0_0000);
    chk1("t2 pc_en at grant", pc_en, 1'b1);
    next_cycle();
    @(negedge clk);
    chk1("t2 pc_en after grant", pc_en, 1'b0);
    chk1("t2 no req while waiting", imem_req, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk1("t2 inst_valid", inst_valid, 1'b1);
    chk32("t2 inst_pc", inst_pc, 32'hbfc0_0000);
    chk32("t2 inst_data", inst_data, 32'h3c08_0001);
    chk1("t2 inst_exc", inst_exc, 1'b0);
    // t3: ID stalled, queue fills and fetching stops
    repeat (5) next_cycle();
    @(negedge clk);
    chk1("t3 full no req", imem_req, 1'b0);
    chk32("t3 pc frozen", pc_address, 32'hbfc0_0008);
    chk32("t3 head pc", inst_pc, 32'hbfc0_0000);
    next_cycle();
    inst_ready = 1'b1;
    @(negedge clk);
    chk1("t3 no pop bypass", imem_req, 1'b0);
    next_cycle();
    inst_ready = 1'b0;
    @(negedge clk);
    chk1("t3 req after pop", imem_req, 1'b1);
    chk32("t3 req addr", imem_addr, 32'hbfc0_0008);
    chk32("t3 second entry", inst_pc, 32'hbfc0_0004);
    next_cycle();
    inst_ready = 1'b1;
    repeat (8) next_cycle();
    // t4: redirect while a read is outstanding
    wait_grant();
    next_cycle();
    branch_taken   = 1'b1;
    branch_address = 32'h8000_0100;
    @(negedge clk);
    chk1("t4 pc_en on branch", pc_en, 1'b1);
    next_cycle();
    branch_taken = 1'b0;
    @(negedge clk);
    chk1("t4 rvalid dropped", imem_rvalid, 1'b1);
    chk1("t4 queue empty", inst_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("t4 req at target", imem_req, 1'b1);
    chk32("t4 target addr", imem_addr, 32'h8000_0100);
    chk1("t4 still empty", inst_valid, 1'b0);
    // t5: redirect with a full queue and ID ready
    next_cycle();
    inst_ready = 1'b0;
    repeat (10) next_cycle();
    @(negedge clk);
    chk1("t5 full valid", inst_valid, 1'b1);
    chk1("t5 full no req", imem_req, 1'b0);
    next_cycle();
    inst_ready     = 1'b1;
    branch_taken   = 1'b1;
    branch_address = 32'h8000_0200;
    @(negedge clk);
    chk1("t5 pc_en", pc_en, 1'b1);
    next_cycle();
    branch_taken = 1'b0;
    @(negedge clk);
    chk1("t5 flushed", inst_valid, 1'b0);
    chk32("t5 flushed pc", inst_pc, 32'h0);
    chk32("t5 target addr", imem_addr, 32'h8000_0200);
    // t6: misaligned target produces an exception entry and halts fetch
    next_cycle();
    inst_ready = 1'b0;
    repeat (10) next_cycle();
    branch_taken   = 1'b1;
    branch_address = 32'hbfc0_0002;
    next_cycle();
    branch_taken = 1'b0;
    @(negedge clk);
    chk1("t6 no req misaligned", imem_req, 1'b0);
    chk1("t6 no pc_en", pc_en, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("t6 exc valid", inst_valid, 1'b1);
    chk1("t6 exc flag", inst_exc, 1'b1);
    chk32("t6 exc data", inst_data, 32'h0);
    chk32("t6 exc pc", inst_pc, 32'hbfc0_0002);
    repeat (3) next_cycle();
    @(negedge clk);
    chk1("t6 halted pc_en", pc_en, 1'b0);
    chk1("t6 halted req", imem_req, 1'b0);
    chk32("t6 pc held", pc_address, 32'hbfc0_0002);
    next_cycle();
    branch_taken   = 1'b1;
    branch_address = 32'hbfc0_0100;
    inst_ready     = 1'b1;
    @(negedge clk);
    chk1("t6 resume pc_en", pc_en, 1'b1);
    next_cycle();
    branch_taken = 1'b0;
    gnt_en       = 1'b0;
    @(negedge clk);
    chk1("t6 resume req", imem_req, 1'b1);
    chk32("t6 resume addr", imem_addr, 32'hbfc0_0100);
    // request held without grant
    repeat (3) next_cycle();
    @(negedge clk);
    chk1("stall req held", imem_req, 1'b1);
    chk32("stall addr held", imem_addr, 32'hbfc0_0100);
    chk1("stall no pc_en", pc_en, 1'b0);
    next_cycle();
    gnt_en    = 1'b1;
    rsp_delay = 1;
    repeat (12) next_cycle();
    // reset while a read is outstanding
    wait_grant();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk1("rst mid-wait req", imem_req, 1'b1);
    chk32("rst mid-wait addr", imem_addr, BOOT);
    chk1("rst mid-wait empty", inst_valid, 1'b0);
    repeat (6) next_cycle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
